// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO with count, almost flags, sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered.
module fifo_sync_flags #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 32,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       wrEn,
  input  logic [WIDTH-1:0]           dataIn,
  input  logic                       rdEn,
  output logic [WIDTH-1:0]           dataOut,
  input  logic                       clrErr,
  output logic                       empty,
  output logic                       full,
  output logic                       almostEmpty,
  output logic                       almostFull,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic          wr_ok, rd_ok;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          ae_q, ae_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  always_comb begin
    wr_ok    = wrEn && !full_q;
    rd_ok    = rdEn && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok)
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
    if (rd_ok)
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Flags come from the next count so they line up with count itself.
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
    ae_d    = (count_d <= CW'(AE_THRESH));
    af_d    = (count_d >= CW'(AF_THRESH));
    // A fresh error beats a same-cycle clear.
    ovf_d   = (wrEn && full_q) || (ovf_q && !clrErr);
    unf_d   = (rdEn && empty_q) || (unf_q && !clrErr);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr_q] <= dataIn;
  end

`ifdef FIFO_FWFT_EN
  assign dataOut = empty_q ? '0 : mem[rd_ptr_q];
`else
  logic [WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (rd_ok)
      dout_d = mem[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)
      dout_q <= '0;
    else
      dout_q <= dout_d;
  end

  assign dataOut = dout_q;
`endif

  assign empty       = empty_q;
  assign full        = full_q;
  assign almostEmpty = ae_q;
  assign almostFull  = af_q;
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule
